h_timing_detect: RTL and testbench
==================================

H_TIMING_DETECT -- requirements
Module: h_timing_detect

Interface
REQ-001 Parameter HSYNC_POL, default 1, sets the hsync active level (1 = active-high, 0 = active-low).
REQ-002 Parameter LOCK_LINES, default 2, is the number of consecutive identical measured lines required for lock (range 1..15).
REQ-003 clock_50  input  1  pixel clock, one pixel per cycle; the block has one clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 hsync  input  1  incoming horizontal sync, polarity per HSYNC_POL.
REQ-006 de  input  1  incoming data enable, active-high.
REQ-007 h_sync_length, h_back_porch, h_active_pixels, h_front_porch, h_total_pixels  output  12 each  last committed line measurement.
REQ-008 meas_valid  output  1  one-cycle pulse when the measurement outputs update.
REQ-009 locked  output  1  timing is stable over LOCK_LINES lines.

Function
REQ-010 The block SHALL register hsync once (hs_d) and define the leading edge as hsync active while hs_d is inactive.
REQ-011 The FSM SHALL have the states SEEK, SYNC, BP, ACTIVE and FP.
REQ-012 SEEK->SYNC occurs on a leading edge, SYNC->BP when hsync goes inactive, BP->ACTIVE when de rises, ACTIVE->FP when de falls, and FP->SYNC on a leading edge (commit).
REQ-013 Each segment count SHALL include its entry cycle: sync = cycles hsync active, bp = cycles from hsync inactive to first de, active = cycles de high, fp = cycles de low until the next leading edge.
REQ-014 h_total_pixels SHALL equal sync+bp+active+fp, computed in 12 bits; commit SHALL be blocked if the sum exceeds 4095.
REQ-015 On commit, all five outputs SHALL update and meas_valid SHALL pulse in the cycle after the leading edge (latency 1).
REQ-016 A leading edge in BP is a blank line: the block SHALL discard the counts, re-enter SYNC, and leave the outputs and lock unchanged.
REQ-017 de high in SYNC, de rising in FP, or a leading edge in ACTIVE SHALL abort to SEEK, clear locked, and reset the match count.
REQ-018 Any segment counter reaching 4095 SHALL abort to SEEK, clear locked, and reset the match count.
REQ-019 On commit, a 5-tuple equal to the previous committed tuple SHALL increment the match count (saturating); otherwise the match count SHALL reset to 1.
REQ-020 locked SHALL be 1 while the match count is at least LOCK_LINES and SHALL fall in the same cycle a mismatch commit occurs.
REQ-021 When a commit coincides with an abort condition, the abort SHALL take priority.

Reset
REQ-022 While reset is high, the FSM SHALL be in SEEK, all counters and outputs SHALL be 0, and hs_d SHALL be the inactive level.
REQ-023 Reset asserted mid-line SHALL discard the partial line; measurement restarts at the next leading edge after release.

Configuration
REQ-024 With H_TIMING_DETECT_ERR_EN defined, the block SHALL add output err_count (8 bits, saturating at 255, cleared by reset), which increments on each REQ-017/REQ-018 abort.
REQ-025 Without H_TIMING_DETECT_ERR_EN, the err_count port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding (3 bits: SEEK, SYNC, BP, ACTIVE, FP), the 12-bit timing width constant, and the count saturation value 4095.
REQ-027 The 5-tuple compare and match counter SHALL be one sub-module, h_timing_lock.

Verification
REQ-028 Three lines of sync 96 / bp 48 / active 640 / fp 16 -> outputs 96/48/640/16/800, meas_valid pulses at each commit, locked=1 after the 2nd commit.
REQ-029 Locked at 800 total, then one line with fp 17 -> h_total_pixels=801 and locked=0 in the same cycle; the next two 801 lines -> locked=1.
REQ-030 Locked, then 10 lines with no de -> no meas_valid, outputs hold 800, locked stays 1.
REQ-031 hsync held active for 5000 cycles -> abort at count 4095, state SEEK, locked=0; err_count increments by 1 when the macro is defined.
REQ-032 de asserted during SYNC -> abort to SEEK, locked=0; HSYNC_POL=0 with inverted hsync repeats REQ-028 with identical values.
REQ-033 reset pulsed mid-ACTIVE -> all outputs 0; the next two clean lines give a first commit of 96/48/640/16/800 and locked=1 at the second.

Source files
------------

// File: rtl/h_timing_detect_pkg.sv
// Shared types and constants for the horizontal timing detector:
// FSM state encoding, timing width, counter saturation value and the measurement tuple.
package h_timing_detect_pkg;

  localparam int TW = 12;
  localparam logic [TW-1:0] CNT_SAT  = 12'd4095;
  localparam logic [TW-1:0] CNT_LAST = 12'd4094;

  typedef enum logic [2:0] {
    SEEK   = 3'd0,
    SYNC   = 3'd1,
    BP     = 3'd2,
    ACTIVE = 3'd3,
    FP     = 3'd4
  } h_state_e;

  typedef struct packed {
    logic [TW-1:0] sync;
    logic [TW-1:0] bp;
    logic [TW-1:0] active;
    logic [TW-1:0] fp;
    logic [TW-1:0] total;
  } h_tuple_t;

endpackage

// File: rtl/h_timing_lock.sv
// Holds the last committed line tuple, compares each new commit against it and
// keeps a saturating match count from which the lock flag is derived.
module h_timing_lock
  import h_timing_detect_pkg::*;
#(
  parameter int LOCK_LINES = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     commit_i,
  input  logic     abort_i,
  input  h_tuple_t meas_i,
  output h_tuple_t tuple_o,
  output logic     valid_o,
  output logic     locked_o
);

  localparam logic [3:0] MATCH_MAX = 4'd15;

  h_tuple_t   tuple_q, tuple_d;
  logic [3:0] match_q, match_d;
  logic       valid_q;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    tuple_d = tuple_q;
    match_d = match_q;
    if (abort_i) begin
      match_d = '0;
    end else if (commit_i) begin
      tuple_d = meas_i;
      if (meas_i == tuple_q) match_d = (match_q == MATCH_MAX) ? MATCH_MAX : match_q + 4'd1;
      else                   match_d = 4'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tuple_q <= '0;
      match_q <= '0;
      valid_q <= 1'b0;
    end else begin
      tuple_q <= tuple_d;
      match_q <= match_d;
      valid_q <= commit_i && !abort_i;
    end
  end

  assign tuple_o  = tuple_q;
  assign valid_o  = valid_q;
  assign locked_o = (match_q >= 4'(LOCK_LINES));

endmodule

// File: rtl/h_timing_detect.sv
// Measures hsync/de line timing (sync, back porch, active, front porch, total) and flags lock.
// Define H_TIMING_DETECT_ERR_EN to add the saturating err_count output counting aborted lines.
module h_timing_detect
  import h_timing_detect_pkg::*;
#(
  parameter bit HSYNC_POL  = 1'b1,
  parameter int LOCK_LINES = 2
) (
  input  logic          clock_50,
  input  logic          reset,
  input  logic          hsync,
  input  logic          de,
  output logic [TW-1:0] h_sync_length,
  output logic [TW-1:0] h_back_porch,
  output logic [TW-1:0] h_active_pixels,
  output logic [TW-1:0] h_front_porch,
  output logic [TW-1:0] h_total_pixels,
  output logic          meas_valid,
  output logic          locked
`ifdef H_TIMING_DETECT_ERR_EN
  ,
  output logic [7:0]    err_count
`endif
);

  h_state_e      state_q, state_d;
  logic          hs_d_q;
  logic [TW-1:0] sync_q, sync_d, bp_q, bp_d, act_q, act_d, fp_q, fp_d;
  logic [TW+1:0] sum;
  logic          hs_act, lead, commit, abort, restart;
  h_tuple_t      meas, tuple;

  assign hs_act = (hsync == HSYNC_POL);
  assign lead   = hs_act && (hs_d_q != HSYNC_POL);
  assign sum    = {2'b00, sync_q} + {2'b00, bp_q} + {2'b00, act_q} + {2'b00, fp_q};
  assign meas   = '{sync: sync_q, bp: bp_q, active: act_q, fp: fp_q, total: sum[TW-1:0]};

  always_comb begin
    state_d = state_q;
    sync_d  = sync_q;
    bp_d    = bp_q;
    act_d   = act_q;
    fp_d    = fp_q;
    commit  = 1'b0;
    abort   = 1'b0;
    restart = 1'b0;
    case (state_q)
      SEEK: restart = lead;
      SYNC: begin
        if (de)                    abort = 1'b1;
        else if (!hs_act)          begin state_d = BP; bp_d = 12'd1; end
        else if (sync_q == CNT_LAST) abort = 1'b1;
        else                       sync_d = sync_q + 12'd1;
      end
      BP: begin
        // A new leading edge before any de is a blank line: start over quietly.
        if (lead)                  restart = 1'b1;
        else if (de)               begin state_d = ACTIVE; act_d = 12'd1; end
        else if (bp_q == CNT_LAST) abort = 1'b1;
        else                       bp_d = bp_q + 12'd1;
      end
      ACTIVE: begin
        if (lead)                   abort = 1'b1;
        else if (!de)               begin state_d = FP; fp_d = 12'd1; end
        else if (act_q == CNT_LAST) abort = 1'b1;
        else                        act_d = act_q + 12'd1;
      end
      FP: begin
        if (de)                    abort = 1'b1;
        else if (lead)             begin restart = 1'b1; commit = (sum <= {2'b00, CNT_SAT}); end
        else if (fp_q == CNT_LAST) abort = 1'b1;
        else                       fp_d = fp_q + 12'd1;
      end
      default: state_d = SEEK;
    endcase

    if (abort) begin
      state_d = SEEK;
      sync_d  = '0;
      bp_d    = '0;
      act_d   = '0;
      fp_d    = '0;
    end else if (restart) begin
      // The leading-edge cycle is the first cycle of the sync segment.
      state_d = SYNC;
      sync_d  = 12'd1;
      bp_d    = '0;
      act_d   = '0;
      fp_d    = '0;
    end
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      state_q <= SEEK;
      hs_d_q  <= ~HSYNC_POL;
      sync_q  <= '0;
      bp_q    <= '0;
      act_q   <= '0;
      fp_q    <= '0;
    end else begin
      state_q <= state_d;
      hs_d_q  <= hsync;
      sync_q  <= sync_d;
      bp_q    <= bp_d;
      act_q   <= act_d;
      fp_q    <= fp_d;
    end
  end

  h_timing_lock #(.LOCK_LINES(LOCK_LINES)) u_lock (
    .clk      (clock_50),
    .rst      (reset),
    .commit_i (commit),
    .abort_i  (abort),
    .meas_i   (meas),
    .tuple_o  (tuple),
    .valid_o  (meas_valid),
    .locked_o (locked)
  );

  assign h_sync_length   = tuple.sync;
  assign h_back_porch    = tuple.bp;
  assign h_active_pixels = tuple.active;
  assign h_front_porch   = tuple.fp;
  assign h_total_pixels  = tuple.total;

`ifdef H_TIMING_DETECT_ERR_EN
  logic [7:0] err_q;

  always_ff @(posedge clock_50) begin
    if (reset)                        err_q <= '0;
    else if (abort && err_q != 8'hFF) err_q <= err_q + 8'd1;
  end

  assign err_count = err_q;
`endif

endmodule

// File: tb/tb_h_timing_detect.sv
// Randomized and directed line-level stimulus for two detectors (active-high and active-low hsync),
// checked by a scoreboard fed from a line-level reference model.
module tb_h_timing_detect;

  localparam int LL = 2;

  typedef enum {K_NORM, K_BLANK, K_DE_SYNC, K_LEAD_ACT, K_DE_FP} kind_e;
  typedef struct packed { logic [59:0] t; logic lk; } exp_t;

  logic clk = 1'b0;
  logic reset, hsync, hsync_n, de;
  logic [11:0] sp, bp, ap, fp, tp, sn, bn, an, fn, tn;
  logic mv_p, mv_n, lk_p, lk_n;
`ifdef H_TIMING_DETECT_ERR_EN
  logic [7:0] ec_p, ec_n;
`endif

  always #5 clk = ~clk;
  assign hsync_n = ~hsync;

  h_timing_detect #(.HSYNC_POL(1'b1), .LOCK_LINES(LL)) u_dut_p (
    .clock_50(clk), .reset(reset), .hsync(hsync), .de(de),
    .h_sync_length(sp), .h_back_porch(bp), .h_active_pixels(ap), .h_front_porch(fp),
    .h_total_pixels(tp), .meas_valid(mv_p), .locked(lk_p)
`ifdef H_TIMING_DETECT_ERR_EN
    , .err_count(ec_p)
`endif
  );

  h_timing_detect #(.HSYNC_POL(1'b0), .LOCK_LINES(LL)) u_dut_n (
    .clock_50(clk), .reset(reset), .hsync(hsync_n), .de(de),
    .h_sync_length(sn), .h_back_porch(bn), .h_active_pixels(an), .h_front_porch(fn),
    .h_total_pixels(tn), .meas_valid(mv_n), .locked(lk_n)
`ifdef H_TIMING_DETECT_ERR_EN
    , .err_count(ec_n)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  exp_t q_p[$];
  exp_t q_n[$];

  // Reference model state, kept per line rather than per cycle.
  logic [59:0] m_prev;
  int m_match, m_err;
  bit m_pend;
  int p_s, p_b, p_a, p_f;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_locked();
    return m_match >= LL;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_match = 0; m_pend = 0; m_err = 0;
  endtask

  task automatic model_abort();
    m_match = 0; m_pend = 0;
    if (m_err < 255) m_err++;
  endtask

  // A leading edge closes the previous complete line, committing it when the total fits 12 bits.
  task automatic model_edge();
    int sum;
    logic [59:0] t;
    exp_t e;
    if (m_pend) begin
      sum = p_s + p_b + p_a + p_f;
      if (sum <= 4095) begin
        t = {12'(p_s), 12'(p_b), 12'(p_a), 12'(p_f), 12'(sum)};
        if (t == m_prev) m_match = (m_match < 15) ? m_match + 1 : 15;
        else             m_match = 1;
        m_prev = t;
        e.t  = t;
        e.lk = m_locked();
        q_p.push_back(e);
        q_n.push_back(e);
      end
      m_pend = 0;
    end
  endtask

  task automatic cyc(input bit hs, input bit d);
    @(negedge clk);
    hsync = hs;
    de    = d;
  endtask

  task automatic status();
    check("status_tuple_p", {sp, bp, ap, fp, tp}, m_prev);
    check("status_tuple_n", {sn, bn, an, fn, tn}, m_prev);
    check("status_locked_p", lk_p, m_locked());
    check("status_locked_n", lk_n, m_locked());
`ifdef H_TIMING_DETECT_ERR_EN
    check("status_err_p", ec_p, m_err);
    check("status_err_n", ec_n, m_err);
`endif
  endtask

  task automatic line(input int s, input int b, input int a, input int f, input kind_e k);
    model_edge();
    for (int i = 0; i < s; i++) cyc(1'b1, k == K_DE_SYNC && i == 1);
    for (int i = 0; i < b; i++) cyc(1'b0, 1'b0);
    if (k != K_BLANK)
      for (int i = 0; i < a; i++) cyc(k == K_LEAD_ACT && (i == 2 || i == 3), 1'b1);
    for (int i = 0; i < f; i++) cyc(1'b0, k == K_DE_FP && i == 1);
    if (k inside {K_DE_SYNC, K_LEAD_ACT, K_DE_FP} || s >= 4095 || b >= 4095 || a >= 4095 || f >= 4095)
      model_abort();
    else if (k == K_BLANK)
      m_pend = 0;
    else begin
      m_pend = 1; p_s = s; p_b = b; p_a = a; p_f = f;
    end
    status();
  endtask

  task automatic line_reset(input int s, input int b, input int a, input int f);
    model_edge();
    for (int i = 0; i < s; i++) cyc(1'b1, 1'b0);
    for (int i = 0; i < b; i++) cyc(1'b0, 1'b0);
    for (int i = 0; i < a / 2; i++) cyc(1'b0, 1'b1);
    reset = 1'b1;
    model_reset();
    repeat (3) cyc(1'b0, 1'b1);
    status();
    reset = 1'b0;
    for (int i = a / 2; i < a; i++) cyc(1'b0, 1'b1);
    for (int i = 0; i < f; i++) cyc(1'b0, 1'b0);
    status();
  endtask

  task automatic mon(input bit neg, input logic mv, input logic [59:0] t, input logic lk);
    exp_t e;
    if ((neg ? q_n.size() : q_p.size()) == 0) begin
      check(neg ? "unexpected_valid_n" : "unexpected_valid_p", mv, 1'b0);
      return;
    end
    if (neg) e = q_n.pop_front();
    else     e = q_p.pop_front();
    check(neg ? "commit_tuple_n" : "commit_tuple_p", t, e.t);
    check(neg ? "commit_locked_n" : "commit_locked_p", lk, e.lk);
  endtask

  always @(negedge clk) if (mv_p) mon(1'b0, mv_p, {sp, bp, ap, fp, tp}, lk_p);
  always @(negedge clk) if (mv_n) mon(1'b1, mv_n, {sn, bn, an, fn, tn}, lk_n);

  initial begin
    reset = 1'b1; hsync = 1'b0; de = 1'b0;
    model_reset();
    repeat (4) cyc(1'b0, 1'b0);
    status();
    reset = 1'b0;
    repeat (3) cyc(1'b0, 1'b0);

    // Three standard lines, then blank lines while locked.
    repeat (3) line(96, 48, 640, 16, K_NORM);
    repeat (10) line(96, 48, 640, 16, K_BLANK);
    line(96, 48, 640, 16, K_NORM);
    // A one-pixel longer front porch, then two more of the same.
    repeat (3) line(96, 48, 640, 17, K_NORM);
    line(96, 48, 640, 16, K_NORM);
    // Protocol errors and counter saturation.
    line(96, 48, 640, 16, K_DE_SYNC);
    repeat (2) line(96, 48, 640, 16, K_NORM);
    line(5000, 48, 640, 16, K_NORM);
    repeat (2) line(96, 48, 640, 16, K_NORM);
    line(20, 10, 60, 8, K_LEAD_ACT);
    repeat (2) line(20, 10, 60, 8, K_NORM);
    line(20, 10, 60, 8, K_DE_FP);
    // Reset in the middle of active video, then clean lines.
    line(96, 48, 640, 16, K_NORM);
    line_reset(96, 48, 640, 16);
    repeat (3) line(96, 48, 640, 16, K_NORM);
    // Total at the 12-bit limit, just over it, then at it again.
    line(10, 10, 3975, 100, K_NORM);
    line(10, 10, 3976, 100, K_NORM);
    line(10, 10, 3975, 100, K_NORM);
    line(8, 4, 40, 3, K_NORM);

    for (int n = 0; n < 80; n++) begin
      int s, b, a, f, r;
      kind_e k;
      case ($urandom_range(0, 2))
        0: begin s = 8; b = 4; a = 40; f = 3; end
        1: begin s = 5; b = 6; a = 30; f = 5; end
        default: begin
          s = $urandom_range(3, 12); b = $urandom_range(1, 8);
          a = $urandom_range(6, 50); f = $urandom_range(3, 10);
        end
      endcase
      r = $urandom_range(0, 9);
      k = (r < 6) ? K_NORM : (r == 6) ? K_BLANK : (r == 7) ? K_DE_SYNC : (r == 8) ? K_LEAD_ACT : K_DE_FP;
      line(s, b, a, f, k);
    end

    model_edge();
    repeat (3) cyc(1'b1, 1'b0);
    repeat (6) cyc(1'b0, 1'b0);
    status();
    check("pending_commits_p", q_p.size(), 0);
    check("pending_commits_n", q_n.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
